// File: rtl/exwb_pipe_reg_pkg.sv
// Shared opcode map, bubble encoding and stage-4 FSM states for the 8-bit pipeline.
// Imported by the EX/WB register and its writeback forwarding decoder.
package exwb_pipe_reg_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    // ORI and Shift ignore opcode bit 3, so they are matched on the low three bits.
    localparam logic [2:0] OP_ORI_MASK   = 3'b111;
    localparam logic [2:0] OP_SHIFT_MASK = 3'b011;

    localparam logic [7:0] NOP_INSTR = 8'h0A;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/exwb_pipe_reg_fwd_decode.sv
// Writeback decode: destination register and forwardability of the stage-4 instruction.
// Purely combinational, zero latency; no flow control.
// Backpressure: none, follows its inputs every cycle.
module wb_fwd_decode
    import exwb_pipe_reg_pkg::*;
#(
    parameter int INSTR_W = 8
) (
    input  logic [INSTR_W-1:0] wb_instr,
    input  logic               wb_valid,
    output logic [1:0]         wb_dest,
    output logic               fwd_valid
);

    logic [3:0] opcode;
    logic       writes_reg;

    assign opcode = wb_instr[3:0];

    always_comb begin
        wb_dest    = wb_instr[7:6];
        writes_reg = 1'b0;
        // ORI always targets r1 regardless of its Ra field.
        if (opcode[2:0] == OP_ORI_MASK) begin
            wb_dest = 2'd1;
        end
        case (opcode)
            OP_LOAD, OP_ADD, OP_SUB, OP_NAND: writes_reg = 1'b1;
            default: writes_reg = (opcode[2:0] == OP_ORI_MASK) ||
                                  (opcode[2:0] == OP_SHIFT_MASK);
        endcase
        fwd_valid = wb_valid & writes_reg;
    end

endmodule

// File: rtl/exwb_pipe_reg.sv
// Stage-3 to stage-4 register: selects writeback data, inserts bubbles, latches halt on Stop.
// Latency 1 cycle; stall holds, flush (beats stall) inserts a NOP; frozen once halted.
// Optional retire counter when EXWB_RETIRE_CNT_EN is defined.
module exwb_pipe_reg
    import exwb_pipe_reg_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] ex_instr,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu,
    input  logic [DATA_W-1:0]  ex_mem,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] wb_instr,
    output logic               wb_valid,
    output logic [DATA_W-1:0]  wb_data,
    output logic [1:0]         wb_dest,
    output logic               fwd_valid,
    output logic               halted
`ifdef EXWB_RETIRE_CNT_EN
    ,
    output logic [15:0]        retire_cnt
`endif
);

    state_t state;
    logic   stop_at_wb;

    assign stop_at_wb = wb_valid && (wb_instr[3:0] == OP_STOP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            wb_instr <= NOP_INSTR;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            halted   <= 1'b0;
        end else if (state == ST_RUN) begin
            // Stop freezes the register on the same edge so it stays visible at stage 4.
            if (stop_at_wb) begin
                state  <= ST_HALT;
                halted <= 1'b1;
            end else if (flush || (!stall && !ex_valid)) begin
                wb_instr <= NOP_INSTR;
                wb_valid <= 1'b0;
                wb_data  <= '0;
            end else if (!stall) begin
                wb_instr <= ex_instr;
                wb_valid <= 1'b1;
                wb_data  <= (ex_instr[3:0] == OP_LOAD) ? ex_mem : ex_alu;
            end
        end
    end

`ifdef EXWB_RETIRE_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (state == ST_RUN && wb_valid) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

    wb_fwd_decode #(
        .INSTR_W (INSTR_W)
    ) u_wb_fwd_decode (
        .wb_instr  (wb_instr),
        .wb_valid  (wb_valid),
        .wb_dest   (wb_dest),
        .fwd_valid (fwd_valid)
    );

endmodule

// File: tb/tb_exwb_pipe_reg.sv
// Directed bench for exwb_pipe_reg: capture, data select, bubbles, stall, halt, async reset.
// Retire counter scenarios run only when EXWB_RETIRE_CNT_EN is defined.
module tb_exwb_pipe_reg;

    logic       clock;
    logic       reset;
    logic [7:0] ex_instr;
    logic       ex_valid;
    logic [7:0] ex_alu;
    logic [7:0] ex_mem;
    logic       stall;
    logic       flush;
    logic [7:0] wb_instr;
    logic       wb_valid;
    logic [7:0] wb_data;
    logic [1:0] wb_dest;
    logic       fwd_valid;
    logic       halted;
`ifdef EXWB_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int vectors;
    int miscompares;

    exwb_pipe_reg dut (
        .clock     (clock),
        .reset     (reset),
        .ex_instr  (ex_instr),
        .ex_valid  (ex_valid),
        .ex_alu    (ex_alu),
        .ex_mem    (ex_mem),
        .stall     (stall),
        .flush     (flush),
        .wb_instr  (wb_instr),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_dest   (wb_dest),
        .fwd_valid (fwd_valid),
        .halted    (halted)
`ifdef EXWB_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [7:0] instr, input logic vld,
                         input logic [7:0] alu, input logic [7:0] mem);
        ex_instr = instr;
        ex_valid = vld;
        ex_alu   = alu;
        ex_mem   = mem;
    endtask

    task automatic test_reset();
        ex_instr = 8'h00; ex_valid = 1'b0; ex_alu = 8'h00; ex_mem = 8'h00;
        stall = 1'b0; flush = 1'b0;
        do_reset();
        vectors++; if (wb_instr !== 8'h0A) begin miscompares++; $display("FAIL reset_instr got %h exp 0a", wb_instr); end
        vectors++; if (wb_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid got %b exp 0", wb_valid); end
        vectors++; if (wb_data !== 8'h00)  begin miscompares++; $display("FAIL reset_data got %h exp 00", wb_data); end
        vectors++; if (wb_dest !== 2'd0)   begin miscompares++; $display("FAIL reset_dest got %0d exp 0", wb_dest); end
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fwd got %b exp 0", fwd_valid); end
        vectors++; if (halted !== 1'b0)    begin miscompares++; $display("FAIL reset_halted got %b exp 0", halted); end
    endtask

    task automatic test_add();
        drive(8'h94, 1'b1, 8'h3C, 8'hC3);
        step();
        vectors++; if (wb_instr !== 8'h94) begin miscompares++; $display("FAIL add_instr got %h exp 94", wb_instr); end
        vectors++; if (wb_valid !== 1'b1)  begin miscompares++; $display("FAIL add_valid got %b exp 1", wb_valid); end
        vectors++; if (wb_data !== 8'h3C)  begin miscompares++; $display("FAIL add_data got %h exp 3c", wb_data); end
        vectors++; if (wb_dest !== 2'd2)   begin miscompares++; $display("FAIL add_dest got %0d exp 2", wb_dest); end
        vectors++; if (fwd_valid !== 1'b1) begin miscompares++; $display("FAIL add_fwd got %b exp 1", fwd_valid); end
    endtask

    task automatic test_load_ori();
        drive(8'h40, 1'b1, 8'h11, 8'hA5);
        step();
        vectors++; if (wb_data !== 8'hA5)  begin miscompares++; $display("FAIL load_data got %h exp a5", wb_data); end
        vectors++; if (wb_dest !== 2'd1)   begin miscompares++; $display("FAIL load_dest got %0d exp 1", wb_dest); end
        vectors++; if (fwd_valid !== 1'b1) begin miscompares++; $display("FAIL load_fwd got %b exp 1", fwd_valid); end
        drive(8'hC7, 1'b1, 8'h5A, 8'h99);
        step();
        vectors++; if (wb_data !== 8'h5A)  begin miscompares++; $display("FAIL ori_data got %h exp 5a", wb_data); end
        vectors++; if (wb_dest !== 2'd1)   begin miscompares++; $display("FAIL ori_dest got %0d exp 1", wb_dest); end
        vectors++; if (fwd_valid !== 1'b1) begin miscompares++; $display("FAIL ori_fwd got %b exp 1", fwd_valid); end
    endtask

    task automatic test_flush_stall();
        drive(8'h94, 1'b1, 8'h3C, 8'h00);
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        vectors++; if (wb_instr !== 8'h0A) begin miscompares++; $display("FAIL flush_instr got %h exp 0a", wb_instr); end
        vectors++; if (wb_valid !== 1'b0)  begin miscompares++; $display("FAIL flush_valid got %b exp 0", wb_valid); end
        vectors++; if (wb_data !== 8'h00)  begin miscompares++; $display("FAIL flush_data got %h exp 00", wb_data); end
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL flush_fwd got %b exp 0", fwd_valid); end
    endtask

    task automatic test_stall_hold();
        drive(8'h9B, 1'b1, 8'h77, 8'h00);
        step();
        vectors++; if (fwd_valid !== 1'b1) begin miscompares++; $display("FAIL shift_fwd got %b exp 1", fwd_valid); end
        drive(8'h40, 1'b1, 8'hEE, 8'hFF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (wb_instr !== 8'h9B) begin miscompares++; $display("FAIL stall_instr[%0d] got %h exp 9b", i, wb_instr); end
            vectors++; if (wb_data !== 8'h77)  begin miscompares++; $display("FAIL stall_data[%0d] got %h exp 77", i, wb_data); end
            vectors++; if (wb_valid !== 1'b1)  begin miscompares++; $display("FAIL stall_valid[%0d] got %b exp 1", i, wb_valid); end
        end
        stall = 1'b0;
        // Stall with ex_valid low must still hold, not bubble.
        drive(8'h40, 1'b0, 8'hEE, 8'hFF);
        stall = 1'b1;
        step();
        stall = 1'b0;
        vectors++; if (wb_instr !== 8'h9B) begin miscompares++; $display("FAIL stall_novld_instr got %h exp 9b", wb_instr); end
    endtask

    task automatic test_nonwriting();
        drive(8'h0C, 1'b1, 8'h33, 8'h44);
        step();
        vectors++; if (wb_data !== 8'h33)  begin miscompares++; $display("FAIL undef_data got %h exp 33", wb_data); end
        vectors++; if (wb_valid !== 1'b1)  begin miscompares++; $display("FAIL undef_valid got %b exp 1", wb_valid); end
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL undef_fwd got %b exp 0", fwd_valid); end
        drive(8'h82, 1'b1, 8'h12, 8'h34);
        step();
        vectors++; if (halted !== 1'b0)    begin miscompares++; $display("FAIL undef_halted got %b exp 0", halted); end
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL store_fwd got %b exp 0", fwd_valid); end
        vectors++; if (wb_dest !== 2'd2)   begin miscompares++; $display("FAIL store_dest got %0d exp 2", wb_dest); end
        drive(8'h94, 1'b0, 8'h12, 8'h34);
        step();
        vectors++; if (wb_instr !== 8'h0A) begin miscompares++; $display("FAIL bubble_instr got %h exp 0a", wb_instr); end
        vectors++; if (wb_valid !== 1'b0)  begin miscompares++; $display("FAIL bubble_valid got %b exp 0", wb_valid); end
    endtask

    task automatic test_stop();
        drive(8'h01, 1'b1, 8'h00, 8'h00);
        step();
        vectors++; if (wb_instr !== 8'h01) begin miscompares++; $display("FAIL stop_instr got %h exp 01", wb_instr); end
        vectors++; if (halted !== 1'b0)    begin miscompares++; $display("FAIL stop_early got %b exp 0", halted); end
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL stop_fwd got %b exp 0", fwd_valid); end
        drive(8'h94, 1'b1, 8'h3C, 8'h00);
        for (int i = 0; i < 4; i++) begin
            flush = i[0];
            step();
            vectors++; if (halted !== 1'b1)    begin miscompares++; $display("FAIL halt_sticky[%0d] got %b exp 1", i, halted); end
            vectors++; if (wb_instr !== 8'h01) begin miscompares++; $display("FAIL halt_instr[%0d] got %h exp 01", i, wb_instr); end
            vectors++; if (wb_valid !== 1'b1)  begin miscompares++; $display("FAIL halt_valid[%0d] got %b exp 1", i, wb_valid); end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (wb_instr !== 8'h0A) begin miscompares++; $display("FAIL arst_instr got %h exp 0a", wb_instr); end
        vectors++; if (wb_valid !== 1'b0)  begin miscompares++; $display("FAIL arst_valid got %b exp 0", wb_valid); end
        vectors++; if (halted !== 1'b0)    begin miscompares++; $display("FAIL arst_halted got %b exp 0", halted); end
        step();
        reset = 1'b0;
        drive(8'h94, 1'b1, 8'h3C, 8'h00);
        step();
        vectors++; if (wb_instr !== 8'h94) begin miscompares++; $display("FAIL resume_instr got %h exp 94", wb_instr); end
        vectors++; if (wb_data !== 8'h3C)  begin miscompares++; $display("FAIL resume_data got %h exp 3c", wb_data); end
    endtask

`ifdef EXWB_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        stall = 1'b0; flush = 1'b0;
        drive(8'h00, 1'b0, 8'h00, 8'h00);
        do_reset();
        vectors++; if (retire_cnt !== 16'd0) begin miscompares++; $display("FAIL cnt_reset got %0d exp 0", retire_cnt); end
        drive(8'h94, 1'b1, 8'h01, 8'h00);
        repeat (5) step();
        drive(8'h94, 1'b0, 8'h01, 8'h00);
        repeat (2) step();
        drive(8'h01, 1'b1, 8'h00, 8'h00);
        step();
        drive(8'h94, 1'b1, 8'h01, 8'h00);
        repeat (4) step();
        vectors++; if (retire_cnt !== 16'd6) begin miscompares++; $display("FAIL cnt_stop got %0d exp 6", retire_cnt); end
        vectors++; if (halted !== 1'b1)      begin miscompares++; $display("FAIL cnt_halted got %b exp 1", halted); end
        do_reset();
        drive(8'h94, 1'b1, 8'h01, 8'h00);
        repeat (65536) step();
        vectors++; if (retire_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL cnt_max got %h exp ffff", retire_cnt); end
        step();
        vectors++; if (retire_cnt !== 16'h0000) begin miscompares++; $display("FAIL cnt_wrap got %h exp 0000", retire_cnt); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        test_reset();
        test_add();
        test_load_ori();
        test_flush_stall();
        test_stall_hold();
        test_nonwriting();
        test_stop();
        test_reset_mid();
`ifdef EXWB_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
